// File: rtl/adc_rr_arbiter.sv
// Round-robin arbiter sharing one soc/eoc A/D converter among N_CLIENTS 4-phase requesters.
// Optional eoc-wait watchdog enabled by defining ADC_TIMEOUT_EN (err is tied 0 otherwise).
module adc_rr_arbiter #(
    parameter int N_CLIENTS   = 4,
    parameter int W           = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clock,
    input  logic                 reset_,
    input  logic [N_CLIENTS-1:0] req,
    output logic [N_CLIENTS-1:0] ack,
    output logic [W-1:0]         dout,
    output logic                 soc,
    input  logic                 eoc,
    input  logic [W-1:0]         x,
    output logic                 err
);

    localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SOC_HI,
        SOC_LO,
        REL
    } state_t;

    state_t               state_q, state_d;
    logic                 soc_q, soc_d;
    logic [N_CLIENTS-1:0] ack_q, ack_d;
    logic [W-1:0]         dout_q, dout_d;
    logic                 err_q, err_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        g_q, g_d;

    logic                 pickValid;
    logic [IW-1:0]        pick;
    logic [IW-1:0]        scanIdx;
    logic [N_CLIENTS-1:0] grantOneHot;
    logic [IW-1:0]        nextPtr;
    logic                 timeoutHit;

    // Scan from ptr upwards with wrap; descending loop so the closest requester is written last.
    always_comb begin
        pickValid = 1'b0;
        pick      = '0;
        scanIdx   = '0;
        for (int k = N_CLIENTS - 1; k >= 0; k--) begin
            if (int'(ptr_q) + k >= N_CLIENTS) begin
                scanIdx = IW'(int'(ptr_q) + k - N_CLIENTS);
            end else begin
                scanIdx = IW'(int'(ptr_q) + k);
            end
            if (req[scanIdx]) begin
                pickValid = 1'b1;
                pick      = scanIdx;
            end
        end
    end

    always_comb begin
        grantOneHot        = '0;
        grantOneHot[g_q]   = 1'b1;
    end

    assign nextPtr = (g_q == IW'(N_CLIENTS - 1)) ? '0 : g_q + 1'b1;

`ifdef ADC_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    // Counter restarts whenever a new eoc wait phase begins, counts while waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE || (state_q == SOC_HI && !eoc)) begin
            cnt_d = '0;
        end else if (state_q == SOC_HI || state_q == SOC_LO) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign timeoutHit = (cnt_q == 8'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock) begin
        if (!reset_) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        soc_d   = soc_q;
        ack_d   = ack_q;
        dout_d  = dout_q;
        err_d   = err_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        unique case (state_q)
            IDLE: begin
                if (eoc && pickValid) begin
                    g_d     = pick;
                    soc_d   = 1'b1;
                    state_d = SOC_HI;
                end
            end
            SOC_HI: begin
                if (!eoc) begin
                    soc_d   = 1'b0;
                    state_d = SOC_LO;
                end else if (timeoutHit) begin
                    soc_d   = 1'b0;
                    err_d   = 1'b1;
                    dout_d  = '1;
                    ack_d   = grantOneHot;
                    state_d = REL;
                end
            end
            SOC_LO: begin
                if (eoc) begin
                    dout_d  = x;
                    ack_d   = grantOneHot;
                    state_d = REL;
                end else if (timeoutHit) begin
                    err_d   = 1'b1;
                    dout_d  = '1;
                    ack_d   = grantOneHot;
                    state_d = REL;
                end
            end
            REL: begin
                if (!req[g_q]) begin
                    ack_d   = '0;
                    ptr_d   = nextPtr;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q <= IDLE;
            soc_q   <= 1'b0;
            ack_q   <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
            g_q     <= '0;
        end else begin
            state_q <= state_d;
            soc_q   <= soc_d;
            ack_q   <= ack_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
        end
    end

    assign soc  = soc_q;
    assign ack  = ack_q;
    assign dout = dout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_adc_rr_arbiter.sv
// Directed bench for adc_rr_arbiter with a behavioural converter answering one cycle per phase.
// The watchdog scenario runs only when ADC_TIMEOUT_EN is defined.
module tb_adc_rr_arbiter;

    logic       clock = 1'b0;
    logic       reset_ = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] ack;
    logic [7:0] dout;
    logic       soc;
    logic       eoc;
    logic [7:0] x;
    logic       err;

    logic       autoAdc = 1'b1;
    logic       eocMan = 1'b1;
    logic [7:0] xMan = 8'h00;
    logic       eocModel = 1'b1;
    logic [7:0] xModel = 8'h00;
    logic [7:0] xNext = 8'h00;

    int compared = 0;
    int mismatched = 0;

    assign eoc = autoAdc ? eocModel : eocMan;
    assign x   = autoAdc ? xModel : xMan;

    adc_rr_arbiter #(
        .N_CLIENTS  (4),
        .W          (8),
        .TIMEOUT_CYC(8)
    ) dut (
        .clock (clock),
        .reset_(reset_),
        .req   (req),
        .ack   (ack),
        .dout  (dout),
        .soc   (soc),
        .eoc   (eoc),
        .x     (x),
        .err   (err)
    );

    always #5 clock = ~clock;

    // Converter: drops eoc one cycle after seeing soc, returns xNext one cycle after soc falls.
    always @(negedge clock) begin
        if (soc === 1'b1 && eocModel) begin
            eocModel = 1'b0;
        end else if (soc === 1'b0 && !eocModel) begin
            eocModel = 1'b1;
            xModel   = xNext;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic waitAck();
        for (int t = 0; t < 20; t++) begin
            if (ack !== 4'b0000) break;
            step();
        end
    endtask

    task automatic doReset();
        reset_  = 1'b0;
        req     = 4'b0000;
        autoAdc = 1'b1;
        eocMan  = 1'b1;
        step();
        step();
        reset_ = 1'b1;
    endtask

    task automatic test_reset();
        reset_  = 1'b0;
        req     = 4'b1111;
        autoAdc = 1'b0;
        eocMan  = 1'b0;
        step();
        step();
        compared++; if (soc !== 1'b0) begin mismatched++; $display("FAIL reset_soc: got %b want 0", soc); end
        compared++; if (ack !== 4'b0000) begin mismatched++; $display("FAIL reset_ack: got %b want 0000", ack); end
        compared++; if (dout !== 8'h00) begin mismatched++; $display("FAIL reset_dout: got %h want 00", dout); end
        compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", err); end
        eocMan = 1'b1;
        reset_ = 1'b1;
        step();
        compared++; if (soc !== 1'b1) begin mismatched++; $display("FAIL reset_first_soc: got %b want 1", soc); end
        xNext   = 8'h5A;
        autoAdc = 1'b1;
        waitAck();
        compared++; if (ack !== 4'b0001) begin mismatched++; $display("FAIL reset_first_grant: got %b want 0001", ack); end
        compared++; if (dout !== 8'h5A) begin mismatched++; $display("FAIL reset_first_dout: got %h want 5a", dout); end
        req = 4'b0000;
        step();
        compared++; if (ack !== 4'b0000) begin mismatched++; $display("FAIL reset_release_ack: got %b want 0000", ack); end
    endtask

    task automatic test_single();
        doReset();
        xNext = 8'hA5;
        req   = 4'b0100;
        step();
        compared++; if (soc !== 1'b1) begin mismatched++; $display("FAIL single_soc_rise: got %b want 1", soc); end
        step();
        compared++; if (soc !== 1'b0) begin mismatched++; $display("FAIL single_soc_fall: got %b want 0", soc); end
        compared++; if (ack !== 4'b0000) begin mismatched++; $display("FAIL single_ack_early: got %b want 0000", ack); end
        step();
        compared++; if (ack !== 4'b0100) begin mismatched++; $display("FAIL single_ack: got %b want 0100", ack); end
        compared++; if (dout !== 8'hA5) begin mismatched++; $display("FAIL single_dout: got %h want a5", dout); end
        req = 4'b0000;
        step();
        compared++; if (ack !== 4'b0000) begin mismatched++; $display("FAIL single_ack_drop: got %b want 0000", ack); end
    endtask

    task automatic test_fairness();
        int c;
        doReset();
        xNext = 8'h10;
        req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            c = k % 4;
            waitAck();
            compared++; if (ack !== 4'(1 << c)) begin mismatched++; $display("FAIL fair_grant%0d: got %b want %b", k, ack, 4'(1 << c)); end
            compared++; if (dout !== 8'((c + 1) * 16)) begin mismatched++; $display("FAIL fair_dout%0d: got %h want %h", k, dout, 8'((c + 1) * 16)); end
            if (k < 4) begin
                req[c] = 1'b0;
                step();
                compared++; if (ack !== 4'b0000) begin mismatched++; $display("FAIL fair_release%0d: got %b want 0000", k, ack); end
                compared++; if (soc !== 1'b0) begin mismatched++; $display("FAIL fair_gap_soc%0d: got %b want 0", k, soc); end
                req[c] = 1'b1;
                xNext  = 8'((((k + 1) % 4) + 1) * 16);
                step();
                compared++; if (soc !== 1'b1) begin mismatched++; $display("FAIL fair_next_soc%0d: got %b want 1", k, soc); end
            end else begin
                req = 4'b0000;
                step();
                compared++; if (ack !== 4'b0000) begin mismatched++; $display("FAIL fair_final_release: got %b want 0000", ack); end
            end
        end
    endtask

    task automatic test_busy();
        doReset();
        autoAdc = 1'b0;
        eocMan  = 1'b0;
        req     = 4'b0001;
        for (int t = 0; t < 10; t++) begin
            step();
            compared++; if (soc !== 1'b0) begin mismatched++; $display("FAIL busy_soc%0d: got %b want 0", t, soc); end
        end
        eocMan = 1'b1;
        step();
        compared++; if (soc !== 1'b1) begin mismatched++; $display("FAIL busy_soc_after: got %b want 1", soc); end
        xNext   = 8'h77;
        autoAdc = 1'b1;
        waitAck();
        compared++; if (ack !== 4'b0001) begin mismatched++; $display("FAIL busy_ack: got %b want 0001", ack); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_early_drop();
        doReset();
        xNext = 8'h55;
        req   = 4'b0110;
        step();
        compared++; if (soc !== 1'b1) begin mismatched++; $display("FAIL drop_soc_rise: got %b want 1", soc); end
        step();
        compared++; if (soc !== 1'b0) begin mismatched++; $display("FAIL drop_soc_fall: got %b want 0", soc); end
        req = 4'b0100;
        step();
        compared++; if (ack !== 4'b0010) begin mismatched++; $display("FAIL drop_ack_pulse: got %b want 0010", ack); end
        compared++; if (dout !== 8'h55) begin mismatched++; $display("FAIL drop_dout: got %h want 55", dout); end
        step();
        compared++; if (ack !== 4'b0000) begin mismatched++; $display("FAIL drop_ack_one_cycle: got %b want 0000", ack); end
        xNext = 8'h66;
        step();
        compared++; if (soc !== 1'b1) begin mismatched++; $display("FAIL drop_next_soc: got %b want 1", soc); end
        waitAck();
        compared++; if (ack !== 4'b0100) begin mismatched++; $display("FAIL drop_next_grant: got %b want 0100", ack); end
        compared++; if (dout !== 8'h66) begin mismatched++; $display("FAIL drop_next_dout: got %h want 66", dout); end
        req = 4'b0000;
        step();
    endtask

`ifdef ADC_TIMEOUT_EN
    task automatic test_timeout();
        doReset();
        autoAdc = 1'b0;
        eocMan  = 1'b1;
        req     = 4'b1000;
        step();
        compared++; if (soc !== 1'b1) begin mismatched++; $display("FAIL to_soc_rise: got %b want 1", soc); end
        for (int t = 1; t < 8; t++) begin
            step();
            compared++; if (soc !== 1'b1) begin mismatched++; $display("FAIL to_soc_held%0d: got %b want 1", t, soc); end
        end
        compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL to_err_early: got %b want 0", err); end
        step();
        compared++; if (soc !== 1'b0) begin mismatched++; $display("FAIL to_soc_drop: got %b want 0", soc); end
        compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL to_err: got %b want 1", err); end
        compared++; if (dout !== 8'hFF) begin mismatched++; $display("FAIL to_dout: got %h want ff", dout); end
        compared++; if (ack !== 4'b1000) begin mismatched++; $display("FAIL to_ack: got %b want 1000", ack); end
        req = 4'b0000;
        step();
        compared++; if (ack !== 4'b0000) begin mismatched++; $display("FAIL to_release: got %b want 0000", ack); end
        autoAdc = 1'b1;
        xNext   = 8'h3C;
        req     = 4'b0001;
        waitAck();
        compared++; if (ack !== 4'b0001) begin mismatched++; $display("FAIL to_recover_ack: got %b want 0001", ack); end
        compared++; if (dout !== 8'h3C) begin mismatched++; $display("FAIL to_recover_dout: got %h want 3c", dout); end
        compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL to_err_sticky: got %b want 1", err); end
        req = 4'b0000;
        step();
    endtask
`else
    task automatic test_err_tied();
        compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL err_tied: got %b want 0", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_busy();
        test_early_drop();
`ifdef ADC_TIMEOUT_EN
        test_timeout();
`else
        test_err_tied();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
